// File: rtl/mm_wb_load_stage.sv
// Writeback-side load stage: holds lane-1 loads until the data cache answers,
// aligns/extends the load data and hands both lanes to the next stage together.
module mm_wb_load_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              next_allowin_i,
  input  logic              line1_pre_to_now_valid_i,
  input  logic              line2_pre_to_now_valid_i,
  output logic              now_allowin_o,
  output logic              line1_now_to_next_valid_o,
  output logic              line2_now_to_next_valid_o,
  input  logic              excep_flush_i,
  input  logic [PC_W-1:0]   l1_pc_i,
  input  logic              l1_load_i,
  input  logic [2:0]        l1_ld_op_i,
  input  logic [1:0]        l1_addr_lo_i,
  input  logic              l1_wb_en_i,
  input  logic [REG_W-1:0]  l1_wb_addr_i,
  input  logic [DATA_W-1:0] l1_alu_res_i,
  input  logic [PC_W-1:0]   l2_pc_i,
  input  logic              l2_wb_en_i,
  input  logic [REG_W-1:0]  l2_wb_addr_i,
  input  logic [DATA_W-1:0] l2_alu_res_i,
  input  logic              dcache_data_ok_i,
  input  logic [DATA_W-1:0] dcache_rdata_i,
  output logic [PC_W-1:0]   l1_pc_o,
  output logic              l1_wb_en_o,
  output logic [REG_W-1:0]  l1_wb_addr_o,
  output logic [DATA_W-1:0] l1_wb_data_o,
  output logic [PC_W-1:0]   l2_pc_o,
  output logic              l2_wb_en_o,
  output logic [REG_W-1:0]  l2_wb_addr_o,
  output logic [DATA_W-1:0] l2_wb_data_o,
  output logic              l1_fwd_data_ok_o,
  output logic              l2_fwd_data_ok_o
);

  // state  | meaning
  // IDLE   | lane 1 empty
  // WAIT   | valid load, cache data not yet returned
  // DONE   | valid, result final
  // CANCEL | flushed load, its cache response must still be swallowed
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_DONE   = 2'd2,
    S_CANCEL = 2'd3
  } l1_state_e;

  l1_state_e l1_state_q, l1_state_d;
  logic      l2_valid_q, l2_valid_d;

  logic [PC_W-1:0]   l1_pc_q, l1_pc_d;
  logic              l1_wb_en_q, l1_wb_en_d;
  logic [REG_W-1:0]  l1_wb_addr_q, l1_wb_addr_d;
  logic [DATA_W-1:0] l1_wb_data_q, l1_wb_data_d;
  logic [2:0]        l1_ld_op_q, l1_ld_op_d;
  logic [1:0]        l1_addr_lo_q, l1_addr_lo_d;
  logic [PC_W-1:0]   l2_pc_q, l2_pc_d;
  logic              l2_wb_en_q, l2_wb_en_d;
  logic [REG_W-1:0]  l2_wb_addr_q, l2_wb_addr_d;
  logic [DATA_W-1:0] l2_wb_data_q, l2_wb_data_d;

  logic              l1_valid;
  logic              l1_data_ok;
  logic              l1_ready_go;
  logic              any_valid;
  logic              accept;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  always_comb begin
    ld_byte = dcache_rdata_i[{l1_addr_lo_q, 3'b000} +: 8];
    ld_half = dcache_rdata_i[{l1_addr_lo_q[1], 4'b0000} +: 16];
    case (l1_ld_op_q)
      3'b000:  ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_ext = dcache_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l1_state_q   <= S_IDLE;
      l2_valid_q   <= 1'b0;
      l1_pc_q      <= '0;
      l1_wb_en_q   <= 1'b0;
      l1_wb_addr_q <= '0;
      l1_wb_data_q <= '0;
      l1_ld_op_q   <= '0;
      l1_addr_lo_q <= '0;
      l2_pc_q      <= '0;
      l2_wb_en_q   <= 1'b0;
      l2_wb_addr_q <= '0;
      l2_wb_data_q <= '0;
    end else begin
      l1_state_q   <= l1_state_d;
      l2_valid_q   <= l2_valid_d;
      l1_pc_q      <= l1_pc_d;
      l1_wb_en_q   <= l1_wb_en_d;
      l1_wb_addr_q <= l1_wb_addr_d;
      l1_wb_data_q <= l1_wb_data_d;
      l1_ld_op_q   <= l1_ld_op_d;
      l1_addr_lo_q <= l1_addr_lo_d;
      l2_pc_q      <= l2_pc_d;
      l2_wb_en_q   <= l2_wb_en_d;
      l2_wb_addr_q <= l2_wb_addr_d;
      l2_wb_data_q <= l2_wb_data_d;
    end
  end

  // An empty lane 1 counts as ready so a lane-2-only bundle leaves at once.
  always_comb begin
    l1_valid    = (l1_state_q == S_WAIT) || (l1_state_q == S_DONE);
    l1_data_ok  = (l1_state_q == S_WAIT) && dcache_data_ok_i;
    l1_ready_go = (l1_state_q == S_IDLE) || (l1_state_q == S_DONE) || l1_data_ok;
    any_valid   = l1_valid || l2_valid_q;
    now_allowin_o = (l1_state_q != S_CANCEL) &&
                    (!any_valid || (l1_ready_go && next_allowin_i));
    accept      = now_allowin_o && !excep_flush_i;
  end

  always_comb begin
    l1_state_d = l1_state_q;
    l2_valid_d = l2_valid_q;
    if (excep_flush_i) begin
      l2_valid_d = 1'b0;
      case (l1_state_q)
        S_WAIT, S_CANCEL: l1_state_d = dcache_data_ok_i ? S_IDLE : S_CANCEL;
        default:          l1_state_d = S_IDLE;
      endcase
    end else if (l1_state_q == S_CANCEL) begin
      if (dcache_data_ok_i) l1_state_d = S_IDLE;
    end else if (accept) begin
      l2_valid_d = line2_pre_to_now_valid_i;
      if (!line1_pre_to_now_valid_i) l1_state_d = S_IDLE;
      else if (l1_load_i)            l1_state_d = S_WAIT;
      else                           l1_state_d = S_DONE;
    end else if (l1_data_ok) begin
      l1_state_d = S_DONE;
    end
  end

  always_comb begin
    l1_pc_d      = l1_pc_q;
    l1_wb_en_d   = l1_wb_en_q;
    l1_wb_addr_d = l1_wb_addr_q;
    l1_wb_data_d = l1_wb_data_q;
    l1_ld_op_d   = l1_ld_op_q;
    l1_addr_lo_d = l1_addr_lo_q;
    l2_pc_d      = l2_pc_q;
    l2_wb_en_d   = l2_wb_en_q;
    l2_wb_addr_d = l2_wb_addr_q;
    l2_wb_data_d = l2_wb_data_q;
    if (accept) begin
      l1_pc_d      = l1_pc_i;
      l1_wb_en_d   = l1_wb_en_i;
      l1_wb_addr_d = l1_wb_addr_i;
      l1_wb_data_d = l1_alu_res_i;
      l1_ld_op_d   = l1_ld_op_i;
      l1_addr_lo_d = l1_addr_lo_i;
      l2_pc_d      = l2_pc_i;
      l2_wb_en_d   = l2_wb_en_i;
      l2_wb_addr_d = l2_wb_addr_i;
      l2_wb_data_d = l2_alu_res_i;
    end else if (l1_data_ok && !excep_flush_i) begin
      l1_wb_data_d = ld_ext;
    end
  end

  always_comb begin
    line1_now_to_next_valid_o = l1_valid && l1_ready_go && !excep_flush_i;
    line2_now_to_next_valid_o = l2_valid_q && l1_ready_go && !excep_flush_i;
    l1_pc_o          = l1_pc_q;
    l1_wb_en_o       = l1_wb_en_q && l1_valid;
    l1_wb_addr_o     = l1_wb_addr_q;
    l1_wb_data_o     = l1_data_ok ? ld_ext : l1_wb_data_q;
    l2_pc_o          = l2_pc_q;
    l2_wb_en_o       = l2_wb_en_q && l2_valid_q;
    l2_wb_addr_o     = l2_wb_addr_q;
    l2_wb_data_o     = l2_wb_data_q;
    l1_fwd_data_ok_o = l1_valid && ((l1_state_q == S_DONE) || l1_data_ok);
    l2_fwd_data_ok_o = l2_valid_q;
  end

endmodule

// File: tb/tb_mm_wb_load_stage.sv
// Bench for mm_wb_load_stage: directed scenarios plus random traffic, checked
// against a transaction-level model of the two lanes.
module tb_mm_wb_load_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        nal, v1, v2, flush, load1, wen1, wen2, dok;
  logic [2:0]  op1;
  logic [1:0]  alo1;
  logic [4:0]  wa1, wa2;
  logic [31:0] pc1, pc2, alu1, alu2, rdata;

  logic        allowin, val1, val2, wen1_o, wen2_o, fwd1, fwd2;
  logic [4:0]  wa1_o, wa2_o;
  logic [31:0] pc1_o, pc2_o, wd1_o, wd2_o;

  mm_wb_load_stage #(.DATA_W(32), .PC_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .next_allowin_i(nal),
    .line1_pre_to_now_valid_i(v1), .line2_pre_to_now_valid_i(v2),
    .now_allowin_o(allowin), .line1_now_to_next_valid_o(val1),
    .line2_now_to_next_valid_o(val2), .excep_flush_i(flush),
    .l1_pc_i(pc1), .l1_load_i(load1), .l1_ld_op_i(op1), .l1_addr_lo_i(alo1),
    .l1_wb_en_i(wen1), .l1_wb_addr_i(wa1), .l1_alu_res_i(alu1),
    .l2_pc_i(pc2), .l2_wb_en_i(wen2), .l2_wb_addr_i(wa2), .l2_alu_res_i(alu2),
    .dcache_data_ok_i(dok), .dcache_rdata_i(rdata),
    .l1_pc_o(pc1_o), .l1_wb_en_o(wen1_o), .l1_wb_addr_o(wa1_o), .l1_wb_data_o(wd1_o),
    .l2_pc_o(pc2_o), .l2_wb_en_o(wen2_o), .l2_wb_addr_o(wa2_o), .l2_wb_data_o(wd2_o),
    .l1_fwd_data_ok_o(fwd1), .l2_fwd_data_ok_o(fwd2)
  );

  int checks = 0;
  int errors = 0;
  int emit1 = 0;
  int emit2 = 0;

  // Model: what each lane holds, whether lane 1 still owes its load data,
  // and whether a cache response must be swallowed after a flush.
  bit          m_v1, m_v2, m_pend, m_drop, m_we1, m_we2;
  logic [31:0] m_pc1, m_pc2, m_d1, m_d2;
  logic [4:0]  m_wa1, m_wa2;
  logic [2:0]  m_op;
  logic [1:0]  m_alo;

  logic [2:0]  x_op  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [1:0]  x_alo [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
  logic [31:0] x_exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012, 32'h00003456};

  function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [1:0] alo,
                                          input logic [31:0] rd);
    int v;
    int sh_b;
    int sh_h;
    sh_b = 8 * int'(alo);
    sh_h = 16 * (int'(alo) / 2);
    case (op)
      3'b000: begin v = int'((rd >> sh_b) & 32'hFF);   if (v > 127)   v = v - 256;   end
      3'b100: v = int'((rd >> sh_b) & 32'hFF);
      3'b001: begin v = int'((rd >> sh_h) & 32'hFFFF); if (v > 32767) v = v - 65536; end
      3'b101: v = int'((rd >> sh_h) & 32'hFFFF);
      default: v = int'(rd);
    endcase
    return 32'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_v1 = 0; m_v2 = 0; m_pend = 0; m_drop = 0;
  endtask

  task automatic clr_in();
    nal = 1'b1; v1 = 1'b0; v2 = 1'b0; flush = 1'b0; load1 = 1'b0; wen1 = 1'b0;
    wen2 = 1'b0; dok = 1'b0; op1 = 3'b010; alo1 = 2'd0; wa1 = 5'd0; wa2 = 5'd0;
    pc1 = 32'h0; pc2 = 32'h0; alu1 = 32'h0; alu2 = 32'h0; rdata = 32'h0;
  endtask

  // Mid-cycle: compare every output with the model, then advance the model
  // with the inputs the DUT will see on the coming edge.
  task automatic sample();
    bit          rg1, ea, ev1, ev2, ef1;
    logic [31:0] ed1;
    #4;
    rg1 = !m_v1 || !m_pend || dok;
    ea  = !m_drop && (!(m_v1 || m_v2) || (rg1 && nal));
    ev1 = m_v1 && rg1 && !flush;
    ev2 = m_v2 && rg1 && !flush;
    ef1 = m_v1 && (!m_pend || dok);
    ed1 = m_pend ? ref_ext(m_op, m_alo, rdata) : m_d1;
    chk1("allowin", allowin, ea);
    chk1("valid1", val1, ev1);
    chk1("valid2", val2, ev2);
    chk1("fwd1", fwd1, ef1);
    chk1("fwd2", fwd2, m_v2);
    chk1("wb_en1", wen1_o, m_v1 && m_we1);
    chk1("wb_en2", wen2_o, m_v2 && m_we2);
    if (ef1) chk("wb_data1", wd1_o, ed1);
    if (m_v1) begin chk("pc1", pc1_o, m_pc1); chk("wb_addr1", 32'(wa1_o), 32'(m_wa1)); end
    if (m_v2) begin
      chk("pc2", pc2_o, m_pc2); chk("wb_addr2", 32'(wa2_o), 32'(m_wa2));
      chk("wb_data2", wd2_o, m_d2);
    end
    if (val1 && nal) emit1++;
    if (val2 && nal) emit2++;
    if (flush) begin
      if (m_drop && dok) m_drop = 0;
      else if (m_v1 && m_pend && !dok) m_drop = 1;
      m_v1 = 0; m_v2 = 0; m_pend = 0;
    end else if (m_drop) begin
      if (dok) m_drop = 0;
    end else if (ea) begin
      m_v1 = v1; m_pend = v1 && load1; m_pc1 = pc1; m_we1 = wen1; m_wa1 = wa1;
      m_d1 = alu1; m_op = op1; m_alo = alo1;
      m_v2 = v2; m_pc2 = pc2; m_we2 = wen2; m_wa2 = wa2; m_d2 = alu2;
    end else if (m_pend && dok) begin
      m_pend = 0; m_d1 = ed1;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cyc();
    sample(); tick();
  endtask

  task automatic offer_load(input logic [31:0] pc, input logic [2:0] op, input logic [1:0] alo);
    clr_in();
    v1 = 1'b1; load1 = 1'b1; wen1 = 1'b1; wa1 = 5'd3; pc1 = pc; op1 = op; alo1 = alo;
  endtask

  int e1_0, e2_0;

  initial begin
    rst_n = 1'b0;
    clr_in();
    model_clear();
    #3;
    chk1("rst_allowin", allowin, 1'b1);
    chk1("rst_valid1", val1, 1'b0);
    chk1("rst_fwd1", fwd1, 1'b0);
    chk("rst_wb_data1", wd1_o, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // LD.W, response on the third cycle after acceptance
    offer_load(32'h100, 3'b010, 2'd0);
    cyc();
    clr_in();
    sample(); chk1("ldw_allowin_w1", allowin, 1'b0); tick();
    sample(); chk1("ldw_allowin_w2", allowin, 1'b0); tick();
    dok = 1'b1; rdata = 32'hDEADBEEF;
    sample(); chk("ldw_data", wd1_o, 32'hDEADBEEF); chk1("ldw_valid", val1, 1'b1); tick();
    clr_in();
    sample(); chk1("ldw_valid_after", val1, 1'b0); tick();

    for (int i = 0; i < 4; i++) begin
      offer_load(32'h180 + 32'(i), x_op[i], x_alo[i]);
      cyc();
      clr_in();
      dok = 1'b1; rdata = 32'h80123456;
      sample(); chk($sformatf("ext%0d", i), wd1_o, x_exp[i]); tick();
      clr_in();
    end

    // async reset while a load waits
    offer_load(32'h1C0, 3'b010, 2'd0);
    cyc();
    clr_in();
    #4;
    rst_n = 1'b0;
    #1;
    chk1("arst_allowin", allowin, 1'b1);
    chk1("arst_valid1", val1, 1'b0);
    chk1("arst_wb_en1", wen1_o, 1'b0);
    chk("arst_pc1", pc1_o, 32'h0);
    model_clear();
    tick(); tick();
    rst_n = 1'b1;

    // response arrives while downstream is stalled
    offer_load(32'h400, 3'b010, 2'd0);
    cyc();
    clr_in();
    nal = 1'b0; dok = 1'b1; rdata = 32'hCAFEF00D;
    cyc();
    dok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample(); chk1("hold_fwd1", fwd1, 1'b1); chk("hold_data", wd1_o, 32'hCAFEF00D); tick();
    end
    nal = 1'b1;
    sample(); chk1("hold_release", val1, 1'b1); chk("hold_rel_data", wd1_o, 32'hCAFEF00D); tick();

    // flush mid-load: first response is dropped, the next load gets the second
    offer_load(32'h200, 3'b010, 2'd0);
    cyc();
    clr_in();
    flush = 1'b1;
    sample(); chk1("flush_valid1", val1, 1'b0); tick();
    offer_load(32'h300, 3'b010, 2'd0);
    sample(); chk1("cancel_allowin", allowin, 1'b0); tick();
    dok = 1'b1; rdata = 32'h11111111;
    sample(); chk1("cancel_allowin2", allowin, 1'b0); chk1("cancel_valid1", val1, 1'b0); tick();
    dok = 1'b0;
    sample(); chk1("cancel_exit_allowin", allowin, 1'b1); tick();
    clr_in();
    cyc();
    dok = 1'b1; rdata = 32'h22222222;
    sample(); chk("new_load_data", wd1_o, 32'h22222222); chk("new_load_pc", pc1_o, 32'h300);
    tick();
    clr_in();

    // ALU pair held and released together
    e1_0 = emit1; e2_0 = emit2;
    v1 = 1'b1; v2 = 1'b1; wen1 = 1'b1; wen2 = 1'b1; wa1 = 5'd5; wa2 = 5'd7;
    alu1 = 32'h5; alu2 = 32'h7; pc1 = 32'h500; pc2 = 32'h504;
    cyc();
    clr_in();
    nal = 1'b0;
    sample(); chk1("pair_held1", val1, 1'b1); chk1("pair_held2", val2, 1'b1);
    chk("pair_d1", wd1_o, 32'h5); chk("pair_d2", wd2_o, 32'h7); tick();
    nal = 1'b1;
    cyc();
    cyc();
    chk("pair_emit1", 32'(emit1 - e1_0), 32'd1);
    chk("pair_emit2", 32'(emit2 - e2_0), 32'd1);

    for (int n = 0; n < 3000; n++) begin
      nal   = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 99) < 3);
      v1    = $urandom_range(0, 1) == 1;
      v2    = $urandom_range(0, 1) == 1;
      load1 = $urandom_range(0, 1) == 1;
      op1   = 3'($urandom_range(0, 7));
      alo1  = 2'($urandom_range(0, 3));
      wen1  = $urandom_range(0, 1) == 1;
      wen2  = $urandom_range(0, 1) == 1;
      wa1   = 5'($urandom_range(0, 31));
      wa2   = 5'($urandom_range(0, 31));
      pc1   = $urandom; pc2 = $urandom; alu1 = $urandom; alu2 = $urandom;
      rdata = $urandom;
      dok   = ((m_v1 && m_pend) || m_drop) && ($urandom_range(0, 9) < 4);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mm_wb_load_stage.md
Name: mm_wb_load_stage

Overview:
- Dual-lane pipeline stage directly downstream of the memory-access (MM) stage; consumes its per-lane results and the data-cache response for lane 1.
- Holds lane-1 loads until the data cache returns data, then aligns and extends the load data.
- Presents writeback data and forwarding data to the next stage and to the issue logic, using the same valid/allowin handshake as the rest of the pipeline.
- Only lane 1 issues memory ops; lane 2 carries ALU results only.

Parameters:
DATA_W, 32, datapath/GPR width
PC_W, 32, PC width
REG_W, 5, GPR index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
next_allowin_i  in  1  downstream stage can accept
line1_pre_to_now_valid_i  in  1  lane-1 MM result valid
line2_pre_to_now_valid_i  in  1  lane-2 MM result valid
now_allowin_o  out  1  this stage accepts both lanes this cycle
line1_now_to_next_valid_o  out  1  lane-1 result valid to next stage
line2_now_to_next_valid_o  out  1  lane-2 result valid to next stage
excep_flush_i  in  1  exception flush, kills both lanes
l1_pc_i  in  PC_W  lane-1 PC
l1_load_i  in  1  lane-1 is a load awaiting a cache response
l1_ld_op_i  in  3  000 LD.B, 001 LD.H, 010 LD.W, 100 LD.BU, 101 LD.HU
l1_addr_lo_i  in  2  load address bits [1:0]
l1_wb_en_i  in  1  lane-1 GPR write enable
l1_wb_addr_i  in  REG_W  lane-1 destination register
l1_alu_res_i  in  DATA_W  lane-1 non-load result
l2_pc_i, l2_wb_en_i, l2_wb_addr_i, l2_alu_res_i  in  PC_W/1/REG_W/DATA_W  lane-2 equivalents
dcache_data_ok_i  in  1  data-cache read response strobe
dcache_rdata_i  in  DATA_W  data-cache read data
l1_pc_o, l1_wb_en_o, l1_wb_addr_o, l1_wb_data_o  out  PC_W/1/REG_W/DATA_W  lane-1 result to next stage
l2_pc_o, l2_wb_en_o, l2_wb_addr_o, l2_wb_data_o  out  same  lane-2 result to next stage
l1_fwd_data_ok_o  out  1  lane-1 wb data is final; 0 while a load is pending
l2_fwd_data_ok_o  out  1  lane-2 wb data is final (equals lane-2 valid)

Behaviour:
- Reset: all valids 0, lane state IDLE, all payload registers 0, now_allowin_o=1, fwd_data_ok outputs 0.
- Accept: when now_allowin_o=1, both lanes' payloads are latched on the next edge. Each lane's valid is set to its pre_to_now_valid_i.
- Per-lane wb_en_o is gated by that lane's valid.
- Lane-1 states:
  - IDLE: empty.
  - WAIT: valid load, no data yet.
  - DONE: valid and result final.
  - CANCEL: flushed load whose response is still owed.
- Transitions:
  - Accept non-load: go to DONE.
  - Accept load: go to WAIT.
  - WAIT with dcache_data_ok_i: capture the extended data, go to DONE (or leave if passed through this cycle).
  - Output handshake: DONE or WAIT, with next_allowin_i, moves to IDLE or to the newly accepted instruction.
- ready_go for lane 1 = DONE, or WAIT with dcache_data_ok_i (same-cycle pass-through: extended rdata drives l1_wb_data_o combinationally).
- now_allowin_o = !(any valid) | (l1_ready_go & lane2 ready & next_allowin_i). Forced 0 in CANCEL.
- lineN_now_to_next_valid_o = lineN valid & l1_ready_go & !excep_flush_i. Both lanes leave together.
- Load extension selects from rdata by addr_lo:
  - B/BU: byte at addr_lo×8.
  - H/HU: halfword at addr_lo[1]×16; addr_lo[0] is ignored.
  - W: full word.
  - B/H sign-extend; BU/HU zero-extend.
  - Undefined ld_op encodings return the full word.
- excep_flush_i: both valids are cleared next edge, and nothing is accepted that cycle.
  - Lane 1 in WAIT without data_ok that cycle goes to CANCEL.
  - CANCEL drops the next dcache_data_ok_i response, then goes to IDLE. now_allowin_o returns to 1 the following cycle.
  - A flush and a data_ok in the same WAIT cycle go straight to IDLE.
- l1_fwd_data_ok_o = valid & (DONE | WAIT&data_ok). l2_fwd_data_ok_o = lane-2 valid.
- A lane-2-only bundle (lane 1 invalid) is ready immediately.

Test Plan:
- Reset asserted mid-WAIT → valids 0, state IDLE, now_allowin_o=1 asynchronously, outputs 0.
- Lane-1 LD.W accepted, data_ok with 0xDEADBEEF 3 cycles later, next_allowin_i=1 → l1_wb_data_o=0xDEADBEEF and valid exactly that cycle; now_allowin_o=0 for the 2 prior cycles.
- LD.B addr_lo=3, rdata 0x80123456 → 0xFFFFFF80. LD.BU → 0x00000080. LD.H addr_lo=2 → 0xFFFF8012. LD.HU addr_lo=0 → 0x00003456.
- Data_ok arrives while next_allowin_i=0 → data captured in DONE; released unchanged when next_allowin_i rises 4 cycles later; l1_fwd_data_ok_o=1 throughout.
- Flush during WAIT, then new load offered, response 0x11111111 arrives 2 cycles later, second response 0x22222222 later → first response dropped; new load accepted only after CANCEL exits; new load outputs 0x22222222.
- Dual-lane ALU pair (0x5, 0x7) with next_allowin_i toggling 1,0,1 → both lanes held together, each emitted exactly once, no loss or duplication.
